// File: rtl/fn1_mul_pkg.sv
// Shared constants and elaboration-time helpers for the fn1_mul pipelined multiplier.
package fn1_mul_pkg;

   localparam int unsigned MIN_NUM_STAGE = 2;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         v = v >> 1;
         r++;
      end
      return r;
   endfunction

   function automatic int unsigned full_width(input int unsigned a_w, input int unsigned b_w);
      return a_w + b_w;
   endfunction

   // Limits are returned as raw bit patterns in the low 'width' bits.
   function automatic logic [63:0] sat_max(input int unsigned width, input bit is_signed);
      return (64'd1 << (width - 32'(is_signed))) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int unsigned width, input bit is_signed);
      return is_signed ? (64'd1 << (width - 1)) : 64'd0;
   endfunction

endpackage

// File: rtl/fn1_mul_valid_pipe.sv
// Valid shift register with synchronous flush and an occupancy counter for the multiplier pipe.
module fn1_mul_valid_pipe
   import fn1_mul_pkg::*;
#(
   parameter int unsigned NUM_STAGE = 4,
   localparam int unsigned CntW = clog2(NUM_STAGE + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ce_i,
   input  logic            clear_i,
   input  logic            valid_i,
   output logic            valid_o,
   output logic [CntW-1:0] inflight_o
);

   logic [NUM_STAGE-1:0] valid_d, valid_q;
   logic [CntW-1:0]      cnt_d, cnt_q;

   always_comb begin
      valid_d = valid_q;
      cnt_d   = cnt_q;
      // Flush wins over advance; a sample arriving with clear is dropped.
      if (clear_i) begin
         valid_d = '0;
         cnt_d   = '0;
      end else if (ce_i) begin
         valid_d = {valid_q[NUM_STAGE-2:0], valid_i};
         unique case ({valid_i, valid_q[NUM_STAGE-1]})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_o    = valid_q[NUM_STAGE-1];
   assign inflight_o = cnt_q;

endmodule

// File: rtl/fn1_mul_pipe_v.sv
// Parametrised pipelined multiplier with valid tracking and product slicing.
// Define FN1_MUL_SAT_EN to saturate the sliced result and drive ovf; otherwise it wraps.
module fn1_mul_pipe_v
   import fn1_mul_pkg::*;
#(
   parameter int unsigned A_WIDTH   = 16,
   parameter int unsigned B_WIDTH   = 16,
   parameter int unsigned P_WIDTH   = 16,
   parameter int unsigned NUM_STAGE = 4,
   parameter int unsigned A_SIGNED  = 1,
   parameter int unsigned B_SIGNED  = 1,
   parameter int unsigned P_SHIFT   = 0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               ce,
   input  logic                               clear,
   input  logic                               in_valid,
   input  logic [A_WIDTH-1:0]                 din0,
   input  logic [B_WIDTH-1:0]                 din1,
   output logic                               out_valid,
   output logic [P_WIDTH-1:0]                 dout,
   output logic                               ovf,
   output logic [clog2(NUM_STAGE + 1)-1:0]    inflight
);

   localparam int unsigned W     = full_width(A_WIDTH, B_WIDTH);
   localparam int unsigned XW    = W + P_WIDTH;
   localparam int unsigned NDLY  = NUM_STAGE - MIN_NUM_STAGE;
   localparam bit          A_SGN = (A_SIGNED != 0);
   localparam bit          B_SGN = (B_SIGNED != 0);
   localparam bit          F_SGN = A_SGN || B_SGN;

   // Stage 1: operand registers.
   logic [A_WIDTH-1:0] a_q;
   logic [B_WIDTH-1:0] b_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q <= '0;
         b_q <= '0;
      end else if (ce) begin
         a_q <= din0;
         b_q <= din1;
      end
   end

   // Extending both operands to W bits makes a W-bit product exact for any signedness mix.
   logic [W-1:0] a_ext, b_ext;
   assign a_ext = {{B_WIDTH{A_SGN & a_q[A_WIDTH-1]}}, a_q};
   assign b_ext = {{A_WIDTH{B_SGN & b_q[B_WIDTH-1]}}, b_q};

   // f_chain[0] is the combinational product; g_dly[1] is stage 2, the rest are delay stages.
   // With NUM_STAGE=2 the product feeds the output slice register directly.
   logic [W-1:0] f_chain [NDLY+1];
   assign f_chain[0] = a_ext * b_ext;

   for (genvar i = 1; i <= NDLY; i++) begin : g_dly
      logic [W-1:0] f_q;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            f_q <= '0;
         end else if (ce) begin
            f_q <= f_chain[i-1];
         end
      end
      assign f_chain[i] = f_q;
   end

   logic [W-1:0]         f_last;
   logic signed [XW-1:0] f_ext;
   logic [P_WIDTH-1:0]   res_d, dout_q;

   assign f_last = f_chain[NDLY];
   assign f_ext  = {{P_WIDTH{F_SGN & f_last[W-1]}}, f_last};

`ifdef FN1_MUL_SAT_EN
   localparam logic [P_WIDTH-1:0] P_MAX = P_WIDTH'(sat_max(P_WIDTH, F_SGN));
   localparam logic [P_WIDTH-1:0] P_MIN = P_WIDTH'(sat_min(P_WIDTH, F_SGN));

   logic signed [XW-1:0] f_sh;
   logic                 ovf_d, ovf_q;

   always_comb begin
      f_sh  = f_ext >>> P_SHIFT;
      res_d = f_sh[P_WIDTH-1:0];
      ovf_d = 1'b0;
      if (F_SGN) begin
         // The kept sign bit and everything above it must agree.
         if (f_sh[XW-1:P_WIDTH-1] != {(W + 1){f_sh[XW-1]}}) begin
            ovf_d = 1'b1;
            res_d = f_sh[XW-1] ? P_MIN : P_MAX;
         end
      end else if (f_sh[XW-1:P_WIDTH] != '0) begin
         ovf_d = 1'b1;
         res_d = P_MAX;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else if (ce) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign res_d = P_WIDTH'(f_ext >>> P_SHIFT);
   assign ovf   = 1'b0;
`endif

   // Final stage holds the sliced result so dout is a flop output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q <= '0;
      end else if (ce) begin
         dout_q <= res_d;
      end
   end

   assign dout = dout_q;

   fn1_mul_valid_pipe #(
      .NUM_STAGE(NUM_STAGE)
   ) u_valid_pipe (
      .clk_i      (clk),
      .rst_ni     (reset),
      .ce_i       (ce),
      .clear_i    (clear),
      .valid_i    (in_valid),
      .valid_o    (out_valid),
      .inflight_o (inflight)
   );

endmodule

// File: tb/tb_fn1_mul_pipe_v.sv
// Directed self-checking bench for fn1_mul_pipe_v: default, unsigned/shifted and signed/shifted builds.
module tb_fn1_mul_pipe_v;

   logic        clk = 1'b0;
   logic        reset, ce, clear, in_valid;
   logic [15:0] din0, din1;
   logic        out_valid, ovf, uns_valid, uns_ovf, sgn_valid, sgn_ovf;
   logic [15:0] dout, uns_dout, sgn_dout;
   logic [2:0]  inflight, uns_inflight, sgn_inflight;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] val;
      int          cap;
   } item_t;

   item_t       q[$];
   int          idx, emitted, ce_cnt;
   bit          shown;
   logic [15:0] shown_val;
   logic [15:0] ce_pat;

   always #5 clk = ~clk;

   fn1_mul_pipe_v u_dut (
      .clk(clk), .reset(reset), .ce(ce), .clear(clear), .in_valid(in_valid),
      .din0(din0), .din1(din1), .out_valid(out_valid), .dout(dout), .ovf(ovf),
      .inflight(inflight)
   );

   fn1_mul_pipe_v #(.A_SIGNED(0), .B_SIGNED(0), .P_SHIFT(16)) u_uns (
      .clk(clk), .reset(reset), .ce(ce), .clear(clear), .in_valid(in_valid),
      .din0(din0), .din1(din1), .out_valid(uns_valid), .dout(uns_dout), .ovf(uns_ovf),
      .inflight(uns_inflight)
   );

   fn1_mul_pipe_v #(.P_SHIFT(16)) u_sgn (
      .clk(clk), .reset(reset), .ce(ce), .clear(clear), .in_valid(in_valid),
      .din0(din0), .din1(din1), .out_valid(sgn_valid), .dout(sgn_dout), .ovf(sgn_ovf),
      .inflight(sgn_inflight)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One sample in, wait for it to reach the output (capture edge counts as the first).
   task automatic one_shot(input logic [15:0] a, input logic [15:0] b);
      ce       = 1'b1;
      in_valid = 1'b1;
      din0     = a;
      din1     = b;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
   endtask

   initial begin
      reset    = 1'b0;
      ce       = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      din0     = '0;
      din1     = '0;
      ce_pat   = 16'b1101_0110_1110_0101;
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_inflight", inflight, 0);
      reset = 1'b1;
      tick();

      // -3 * 7 = -21
      ce       = 1'b1;
      in_valid = 1'b1;
      din0     = 16'hFFFD;
      din1     = 16'd7;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) tick();
         check("t1_valid", out_valid, (k == 4) ? 1 : 0);
         check("t1_inflight", inflight, (k <= 4) ? 1 : 0);
         if (k == 4) begin
            check("t1_dout", dout, 16'hFFEB);
            check("t1_ovf", ovf, 0);
         end
      end

      // 0xFFFF * 0xFFFF, slice from bit 16
      one_shot(16'hFFFF, 16'hFFFF);
      check("uns_valid", uns_valid, 1);
      check("uns_dout", uns_dout, 16'hFFFE);
      check("uns_ovf", uns_ovf, 0);
      check("uns_inflight", uns_inflight, 1);
      check("sgn_valid", sgn_valid, 1);
      check("sgn_dout", sgn_dout, 16'h0000);
      check("sgn_ovf", sgn_ovf, 0);
      check("sgn_inflight", sgn_inflight, 1);
      tick();

      // 0x7FFF * 0x7FFF = 0x3FFF0001
      one_shot(16'h7FFF, 16'h7FFF);
      check("big_valid", out_valid, 1);
`ifdef FN1_MUL_SAT_EN
      check("big_dout_sat", dout, 16'h7FFF);
      check("big_ovf_sat", ovf, 1);
`else
      check("big_dout_wrap", dout, 16'h0001);
      check("big_ovf_wrap", ovf, 0);
`endif
      check("big_uns_dout", uns_dout, 16'h3FFF);
      check("big_sgn_dout", sgn_dout, 16'h3FFF);
      tick();
      check("big_drain", inflight, 0);

      // Ten samples (i*3) x (i+1) with ce gated by a fixed pattern.
      idx     = 0;
      emitted = 0;
      ce_cnt  = 0;
      shown   = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (emitted == 10 && !shown) break;
         ce       = ce_pat[cyc % 16];
         in_valid = (idx < 10);
         din0     = 16'(idx * 3);
         din1     = 16'(idx + 1);
         tick();
         if (ce) begin
            ce_cnt++;
            shown = 1'b0;
            if (in_valid) begin
               q.push_back('{val: 16'(idx * 3 * (idx + 1)), cap: ce_cnt});
               idx++;
            end
            if (q.size() > 0 && q[0].cap == ce_cnt - 3) begin
               shown     = 1'b1;
               shown_val = q[0].val;
               void'(q.pop_front());
               emitted++;
            end
         end
         check("tog_valid", out_valid, shown);
         if (shown) check("tog_dout", dout, shown_val);
         check("tog_inflight", inflight, q.size() + shown);
      end
      check("tog_emitted", emitted, 10);

      // Clear with three items in flight and a new sample offered.
      ce = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         din0     = 16'(i + 2);
         din1     = 16'd5;
         tick();
      end
      check("clr_pre_inflight", inflight, 3);
      clear    = 1'b1;
      in_valid = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clr_inflight", inflight, 0);
      check("clr_valid", out_valid, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("clr_hold_valid", out_valid, 0);
         check("clr_hold_inflight", inflight, 0);
      end

      // Asynchronous reset with two items in flight, one on the output.
      in_valid = 1'b1;
      din0     = 16'd9;
      din1     = 16'd9;
      tick();
      din0 = 16'd10;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("ar_pre_valid", out_valid, 1);
      check("ar_pre_dout", dout, 16'd81);
      check("ar_pre_inflight", inflight, 2);
      #3 reset = 1'b0;
      #1;
      check("ar_valid", out_valid, 0);
      check("ar_dout", dout, 0);
      check("ar_inflight", inflight, 0);
      check("ar_ovf", ovf, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("ar_post_valid", out_valid, 0);
      end
      // -2 * 100 = -200
      in_valid = 1'b1;
      din0     = 16'hFFFE;
      din1     = 16'd100;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) tick();
         check("ar_new_valid", out_valid, (k == 4) ? 1 : 0);
      end
      check("ar_new_dout", dout, 16'hFF38);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fn1_mul_pipe_v.md
Name: fn1_mul_pipe_v

Overview:
- Parametrised pipelined multiplier, successor to the fixed 16x16->16, 4-stage HLS multiplier core.
- Generic operand/result widths, per-operand signedness, programmable depth and product slice.
- Adds a valid pipeline with synchronous flush and an in-flight counter, so schedulers can track occupancy.
- Instantiated by generated datapaths wherever a multi-cycle multiply (mul_mul_*) is bound.

Parameters:
- A_WIDTH, 16, din0 width (1..32).
- B_WIDTH, 16, din1 width (1..32).
- P_WIDTH, 16, dout width (1..64).
- NUM_STAGE, 4, latency in ce-enabled cycles; legal range >= 2.
- A_SIGNED, 1, 1 = din0 is two's complement, 0 = unsigned.
- B_SIGNED, 1, 1 = din1 is two's complement, 0 = unsigned.
- P_SHIFT, 0, arithmetic right shift applied to the full product before slicing (0..A_WIDTH+B_WIDTH-1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  pipeline advance enable; all state holds when 0.
- clear  in  1  synchronous flush of valid bits and counter.
- in_valid  in  1  din0/din1 qualify this cycle.
- din0  in  A_WIDTH  operand A.
- din1  in  B_WIDTH  operand B.
- out_valid  out  1  dout carries a result.
- dout  out  P_WIDTH  sliced product.
- ovf  out  1  result lost significant bits (see Optional Feature).
- inflight  out  clog2(NUM_STAGE+1)  number of valid items inside the pipe.

Behaviour:
- Reset (reset=0, asynchronous): every register cleared; out_valid=0, dout=0, ovf=0, inflight=0. Release is synchronous to clk.
- Datapath structure:
  - Stage 1 registers the operands.
  - Stage 2 registers full product F, width W=A_WIDTH+B_WIDTH. Each operand is extended per its *_SIGNED flag; F is signed if either operand is signed.
  - Stages 3..NUM_STAGE are delay registers. NUM_STAGE=2 has no delay stages.
- Slice:
  - dout = (F >>> P_SHIFT)[P_WIDTH-1:0]; the shift is arithmetic if F is signed, else logical.
  - If P_WIDTH exceeds W-P_SHIFT, the result is sign- or zero-extended.
  - The slice is taken at the final stage register so dout is a flop output.
- Latency and throughput:
  - A sample with in_valid=1 on ce cycle k appears with out_valid=1 after exactly NUM_STAGE ce=1 edges.
  - Throughput is one per ce cycle.
- ce=0: all data, valid and counter registers hold. Outputs stay stable; out_valid may remain 1 for multiple cycles.
- Valid pipe:
  - NUM_STAGE-bit shift register, advancing only on ce=1.
  - in_valid is ignored when ce=0; the sample is not captured.
  - Data registers advance on ce regardless of valid. dout content is don't-care when out_valid=0.
- clear=1:
  - All valid bits and inflight go to 0 at the next edge.
  - clear has priority over ce and in_valid. A sample presented with clear is dropped.
  - Data registers are unaffected.
- inflight:
  - Next value = inflight + (ce & in_valid) - (ce & last-stage valid).
  - Simultaneous entry and exit leaves it unchanged. Never exceeds NUM_STAGE; never wraps.
  - inflight counts items in stages 1..NUM_STAGE, including the one currently on out_valid.
- Reset mid-operation: all in-flight items are discarded; no partial result ever appears after release.

Optional Feature:
- Macro: FN1_MUL_SAT_EN.
- Defined:
  - If the bits of F>>>P_SHIFT above P_WIDTH are not all equal to the result sign (signed) or not all zero (unsigned), dout saturates to max/min representable.
  - ovf=1 for that output, aligned with out_valid.
- Undefined:
  - The result wraps (plain truncation).
  - ovf is tied to 0.
  - No comparison logic is synthesised.

Decomposition:
- Package fn1_mul_pkg:
  - clog2 function.
  - MIN_NUM_STAGE=2.
  - Helper functions for full-product width and saturation limits (max/min for a given width and signedness).
- One sub-module, fn1_mul_valid_pipe: valid shift register, clear, and inflight counter (parameter NUM_STAGE).
- Top-level owns the datapath and the slice/saturation logic.

Test Plan:
- Defaults, din0=-3 (0xFFFD), din1=7, in_valid one cycle, ce=1 -> out_valid exactly 4 cycles later, dout=0xFFEB; inflight steps 1,1,1,1 then 0.
- A_SIGNED=B_SIGNED=0, P_SHIFT=16, din0=din1=0xFFFF -> dout=0xFFFE; signed config with same inputs -> dout=0x0000 (F=1).
- Back-to-back 10 samples (i*3 x i+1), ce toggled 1/0 pseudo-randomly -> outputs in order, each emitted after 4 ce=1 edges, inflight never >4, no duplicates or drops.
- clear asserted while 3 items are in flight together with in_valid=1 -> out_valid stays 0 thereafter, inflight=0 next cycle.
- din0=din1=0x7FFF, P_SHIFT=0:
  - Without FN1_MUL_SAT_EN -> dout=0x0001, ovf=0.
  - With FN1_MUL_SAT_EN -> dout=0x7FFF, ovf=1.
- reset pulsed low asynchronously (mid-cycle) with 2 items in flight -> outputs zero immediately; no out_valid after release until new input plus 4 cycles.
